// File: rtl/logic_unit_pkg.sv
// Shared op-code definitions for the pipelined bitwise logic unit.
package logic_unit_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND   = 3'd0;
    localparam op_t OP_OR    = 3'd1;
    localparam op_t OP_NOT_A = 3'd2;
    localparam op_t OP_NOT_B = 3'd3;
    localparam op_t OP_NAND  = 3'd4;
    localparam op_t OP_NOR   = 3'd5;
    localparam op_t OP_XOR   = 3'd6;
    localparam op_t OP_XNOR  = 3'd7;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational gate evaluation plus result flags (zero, all-ones, parity, popcount).
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int PW    = $clog2(WIDTH + 1)
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones,
    output logic             par,
    output logic [PW-1:0]    pop
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_NOT_A: y = ~a;
            OP_NOT_B: y = ~b;
            OP_NAND:  y = ~(a & b);
            OP_NOR:   y = ~(a | b);
            OP_XOR:   y = a ^ b;
            OP_XNOR:  y = ~(a ^ b);
            default:  y = '0;
        endcase
    end

    assign zero = (y == '0);
    assign ones = &y;
    assign par  = ^y;

    // PW is wide enough to hold WIDTH, so the count never wraps
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + PW'(y[i]);
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline around logic_unit_core: S1 holds operands, S2 holds result and flags.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int PW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_par,
    output logic [PW-1:0]    out_pop
);

    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic [WIDTH-1:0] core_y;
    logic             core_zero;
    logic             core_ones;
    logic             core_par;
    logic [PW-1:0]    core_pop;

    logic s2_free;
    logic s1_move;

    assign s2_free  = !out_valid || out_ready;
    assign s1_move  = s1_valid && s2_free;
    assign in_ready = !s1_valid || s1_move;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_AND;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= in_op;
                s1_a  <= in_a;
                s1_b  <= in_b;
            end
        end
    end

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .op   (s1_op),
        .a    (s1_a),
        .b    (s1_b),
        .y    (core_y),
        .zero (core_zero),
        .ones (core_ones),
        .par  (core_par),
        .pop  (core_pop)
    );

    // Result registers only load on an S1 move, so they hold steady under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_zero  <= 1'b0;
            out_ones  <= 1'b0;
            out_par   <= 1'b0;
            out_pop   <= '0;
        end else begin
            if (s2_free) begin
                out_valid <= s1_valid;
            end
            if (s1_move) begin
                out_y    <= core_y;
                out_zero <= core_zero;
                out_ones <= core_ones;
                out_par  <= core_par;
                out_pop  <= core_pop;
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench: WIDTH=8, 1 and 64 instances share one stimulus stream.
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  in_op;
    logic [63:0] a64;
    logic [63:0] b64;
    logic        out_ready;

    logic        ir8, ov8, zero8, ones8, par8;
    logic [7:0]  y8;
    logic [3:0]  pop8;
    logic        ir1, ov1, zero1, ones1, par1;
    logic [0:0]  y1;
    logic [0:0]  pop1;
    logic        ir64, ov64, zero64, ones64, par64;
    logic [63:0] y64;
    logic [6:0]  pop64;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    typedef struct {
        logic [63:0] y64;
        logic [7:0]  y8;
        logic        y1;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic_unit_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8), .in_op(in_op),
        .in_a(a64[7:0]), .in_b(b64[7:0]), .out_valid(ov8), .out_ready(out_ready),
        .out_y(y8), .out_zero(zero8), .out_ones(ones8), .out_par(par8), .out_pop(pop8)
    );

    logic_unit_pipe #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_op(in_op),
        .in_a(a64[0:0]), .in_b(b64[0:0]), .out_valid(ov1), .out_ready(out_ready),
        .out_y(y1), .out_zero(zero1), .out_ones(ones1), .out_par(par1), .out_pop(pop1)
    );

    logic_unit_pipe #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64), .in_op(in_op),
        .in_a(a64), .in_b(b64), .out_valid(ov64), .out_ready(out_ready),
        .out_y(y64), .out_zero(zero64), .out_ones(ones64), .out_par(par64), .out_pop(pop64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return ~b;
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    // Drives a beat at a falling edge; returns once it will be accepted at the next rising edge.
    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, output int waits);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        a64      = a;
        b64      = b;
        waits    = 0;
        #1;
        while (!ir8 && waits < 40) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!ir8) begin
            check("in_ready_timeout", 64'(ir8), 64'd1);
            return;
        end
        e.y64 = model(op, a, b);
        e.y8  = e.y64[7:0];
        e.y1  = e.y64[0];
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("drain_left", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n && ov8 && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 64'(ov8), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                pop_cyc.push_back(cyc);
                check("y8",     64'(y8),    64'(mon_e.y8));
                check("zero8",  64'(zero8), 64'(mon_e.y8 == 8'h00));
                check("ones8",  64'(ones8), 64'(mon_e.y8 == 8'hFF));
                check("par8",   64'(par8),  64'(^mon_e.y8));
                check("pop8",   64'(pop8),  64'($countones(mon_e.y8)));
                check("ov1",    64'(ov1),   64'd1);
                check("y1",     64'(y1),    64'(mon_e.y1));
                check("zero1",  64'(zero1), 64'(!mon_e.y1));
                check("ones1",  64'(ones1), 64'(mon_e.y1));
                check("par1",   64'(par1),  64'(mon_e.y1));
                check("pop1",   64'(pop1),  64'(mon_e.y1));
                check("ov64",   64'(ov64),  64'd1);
                check("y64",    y64,        mon_e.y64);
                check("zero64", 64'(zero64), 64'(mon_e.y64 == 64'd0));
                check("ones64", 64'(ones64), 64'(mon_e.y64 == '1));
                check("par64",  64'(par64),  64'(^mon_e.y64));
                check("pop64",  64'(pop64),  64'($countones(mon_e.y64)));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] sweep_exp [8];
        logic [7:0] snap_y8;
        logic [63:0] snap_y64;
        int w;

        sweep_exp = '{8'h00, 8'hFF, 8'h3A, 8'hC5, 8'hFF, 8'h00, 8'hFF, 8'h00};

        // Reset held with a beat offered
        rst_n = 1'b0; in_valid = 1'b1; in_op = OP_OR; a64 = '1; b64 = '1; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk); #2;
            check("rst_ov8", 64'(ov8), 64'd0);
            check("rst_y8", 64'(y8), 64'd0);
            check("rst_ov64", 64'(ov64), 64'd0);
            check("rst_y64", y64, 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #2;
        check("rst_in_ready", 64'(ir8), 64'd1);
        check("rst_pop8", 64'(pop8), 64'd0);

        // Op sweep with latency check
        for (int op = 0; op < 8; op++) begin
            send(3'(op), 64'hA5A5_0F0F_1234_56C5, 64'h5A5A_F0F0_0000_FF3A, w);
            idle();
            #2;
            check("lat_s1_only", 64'(ov8), 64'd0);
            @(negedge clk); #2;
            check("lat_out", 64'(ov8), 64'd1);
            check("sweep_y8", 64'(y8), 64'(sweep_exp[op]));
            if (op == 1) begin
                check("or_zero", 64'(zero8), 64'd0);
                check("or_ones", 64'(ones8), 64'd1);
                check("or_pop",  64'(pop8),  64'd8);
            end
        end
        drain();

        // Flags
        send(OP_XOR, 64'h01, 64'h01, w);
        idle();
        @(negedge clk); #2;
        check("flag_xor_y", 64'(y8), 64'h00);
        check("flag_xor_zero", 64'(zero8), 64'd1);
        check("flag_xor_par", 64'(par8), 64'd0);
        check("flag_xor_pop", 64'(pop8), 64'd0);
        send(OP_OR, 64'h07, 64'h00, w);
        idle();
        @(negedge clk); #2;
        check("flag_or_y", 64'(y8), 64'h07);
        check("flag_or_par", 64'(par8), 64'd1);
        check("flag_or_pop", 64'(pop8), 64'd3);
        check("flag_or_pop64", 64'(pop64), 64'd3);
        drain();

        // Back-to-back streaming
        pop_cyc.delete();
        for (int i = 0; i < 16; i++) begin
            send(3'($urandom_range(7)), {$urandom, $urandom}, {$urandom, $urandom}, w);
            check("stream_ready", 64'(w), 64'd0);
        end
        idle();
        drain();
        check("stream_count", 64'(pop_cyc.size()), 64'd16);
        if (pop_cyc.size() == 16)
            check("stream_no_bubble", 64'(pop_cyc[15] - pop_cyc[0]), 64'd15);

        // Backpressure from an empty pipe
        @(negedge clk);
        out_ready = 1'b0;
        send(OP_XOR, 64'h1111_2222_3333_4444, 64'h0F0F_0F0F_0F0F_0F0F, w);
        send(OP_NAND, 64'hFFFF_0000_FFFF_00AA, 64'h00FF_00FF_00FF_00F0, w);
        fork
            send(OP_NOT_A, 64'h0123_4567_89AB_CDEF, 64'd0, w);
            begin
                @(negedge clk); #2;
                check("bp_in_ready", 64'(ir8), 64'd0);
                check("bp_ov8", 64'(ov8), 64'd1);
                snap_y8  = y8;
                snap_y64 = y64;
                repeat (4) begin
                    @(negedge clk); #2;
                    check("bp_hold_ov", 64'(ov8), 64'd1);
                    check("bp_hold_y8", 64'(y8), 64'(snap_y8));
                    check("bp_hold_y64", y64, snap_y64);
                    check("bp_hold_ready", 64'(ir8), 64'd0);
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        idle();
        drain();

        // Reset with two beats in flight
        @(negedge clk);
        out_ready = 1'b0;
        send(OP_OR, 64'hF0, 64'h0F, w);
        send(OP_AND, 64'hFF, 64'h3C, w);
        idle();
        #2;
        check("mid_ov_before", 64'(ov8), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_ov8_async", 64'(ov8), 64'd0);
        check("mid_ov1_async", 64'(ov1), 64'd0);
        check("mid_ov64_async", 64'(ov64), 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
        rst_n     = 1'b1;
        repeat (5) begin
            @(negedge clk); #2;
            check("post_rst_quiet", 64'(ov8), 64'd0);
        end
        send(OP_XNOR, 64'h5A, 64'h0F, w);
        idle();
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
